// File: rtl/id_range_dispatcher.sv
// id_range_dispatcher: buffers [start,end] ID ranges, splits them into bounded chunks
// and hands each chunk to the lowest-index idle scanner lane, accumulating lane sums.
module id_range_dispatcher #(
    parameter int W          = 48,
    parameter int NUM_LANES  = 8,
    parameter int DEPTH      = 16,
    parameter int CHUNK_LOG2 = 20
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [W-1:0]                     in_start,
    input  logic [W-1:0]                     in_end,
    input  logic                             in_last,
    output logic [NUM_LANES-1:0]             lane_load,
    output logic [NUM_LANES-1:0][W-1:0]      lane_start,
    output logic [NUM_LANES-1:0][W-1:0]      lane_end,
    input  logic [NUM_LANES-1:0]             lane_done,
    input  logic [NUM_LANES-1:0][W-1:0]      lane_sum,
    output logic [W-1:0]                     total_sum,
    output logic [7:0]                       err_count,
    output logic [$clog2(DEPTH):0]           fifo_count,
    output logic                             done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [W:0] SPAN = (W+1)'({CHUNK_LOG2{1'b1}});

    logic [W-1:0] mem_start [DEPTH];
    logic [W-1:0] mem_end [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count_n;
    logic closed, closed_n, cur_valid;
    logic [W-1:0] cur_start, cur_end, chunk_end, done_sum;
    logic [W:0] chunk_lim;
    logic [NUM_LANES-1:0] busy, load;
    logic take, push, pop, dispatch;

    assign take = in_valid && in_ready;
    assign push = take && in_start <= in_end;
    assign pop = !cur_valid && fifo_count != '0;
    assign count_n = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    assign closed_n = closed || (take && in_last);
    // W+1-bit limit keeps chunks near the top of the ID space from wrapping
    assign chunk_lim = {1'b0, cur_start} + SPAN;
    assign chunk_end = (chunk_lim > {1'b0, cur_end}) ? cur_end : chunk_lim[W-1:0];
    // lowest clear bit of busy selects the lowest-index idle lane
    assign load = cur_valid ? (~busy & (busy + NUM_LANES'(1))) : '0;
    assign dispatch = |load;

    always_comb begin
        done_sum = '0;
        for (int i = 0; i < NUM_LANES; i++)
            done_sum = done_sum + ((busy[i] && lane_done[i]) ? lane_sum[i] : '0);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_start[wr_ptr] <= in_start;
            mem_end[wr_ptr] <= in_end;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            closed <= 1'b0;
            in_ready <= 1'b0;
            cur_valid <= 1'b0;
            cur_start <= '0;
            cur_end <= '0;
            busy <= '0;
            lane_load <= '0;
            lane_start <= '0;
            lane_end <= '0;
            total_sum <= '0;
            err_count <= '0;
            done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (take && in_start > in_end && err_count != 8'hff)
                err_count <= err_count + 8'd1;
            fifo_count <= count_n;
            closed <= closed_n;
            in_ready <= (count_n < (AW+1)'(DEPTH)) && !closed_n;
            if (pop) begin
                cur_valid <= 1'b1;
                cur_start <= mem_start[rd_ptr];
                cur_end <= mem_end[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end else if (dispatch) begin
                if (chunk_end == cur_end)
                    cur_valid <= 1'b0;
                else
                    cur_start <= chunk_end + W'(1);
            end
            busy <= (busy & ~lane_done) | load;
            lane_load <= load;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (load[i]) begin
                    lane_start[i] <= cur_start;
                    lane_end[i] <= chunk_end;
                end
            end
            total_sum <= total_sum + done_sum;
            if (closed && fifo_count == '0 && !cur_valid && (busy & ~lane_done) == '0)
                done <= 1'b1;
        end
    end
endmodule
